// File: rtl/breakout_pkg.sv
// Shared constants for the Breakout scan-out path: default VGA timing, colours, index sizing.
// Latency: none (package only).
// Backpressure: none (package only).
package breakout_pkg;

    // Default 640x480@60 Hz timing at a 25 MHz pixel clock
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Raster counters are 10 bits wide, enough for an 800-clock line and a 525-line frame
    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] coord_t;
    typedef logic [2:0]       rgb_t;

    localparam rgb_t COL_BLACK  = 3'b000;
    localparam rgb_t COL_BALL   = 3'b101;
    localparam rgb_t COL_PADDLE = 3'b001;

    // Brick row palette, repeating every five rows
    localparam rgb_t COL_ROW0 = 3'b010;
    localparam rgb_t COL_ROW1 = 3'b110;
    localparam rgb_t COL_ROW2 = 3'b111;
    localparam rgb_t COL_ROW3 = 3'b100;
    localparam rgb_t COL_ROW4 = 3'b011;

    function automatic rgb_t row_colour(input int row);
        rgb_t col;
        case (row % 5)
            0:       col = COL_ROW0;
            1:       col = COL_ROW1;
            2:       col = COL_ROW2;
            3:       col = COL_ROW3;
            default: col = COL_ROW4;
        endcase
        return col;
    endfunction

    // Brick index width; a single-brick field still needs a one-bit index port
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus registered hsync/vsync/frame_start decoded from them.
// Latency: counters are the state; sync and frame_start lag the counters by 1 clock.
// Backpressure: none, free-running from the first clock after reset release.
module vga_timing_gen
    import breakout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;

    // Raster advance: wrap the line at H_TOTAL, then the frame at V_TOTAL
    always_comb begin
        h_d = h_q + coord_t'(1);
        v_d = v_q;
        if (h_q == coord_t'(H_TOTAL - 1)) begin
            h_d = '0;
            if (v_q == coord_t'(V_TOTAL - 1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + coord_t'(1);
            end
        end
    end

    // Sync windows and the top-left marker for the pixel the counters point at now
    always_comb begin
        hsync_d       = !((h_q >= coord_t'(HS_START)) && (h_q < coord_t'(HS_END)));
        vsync_d       = !((v_q >= coord_t'(VS_START)) && (v_q < coord_t'(VS_END)));
        frame_start_d = (h_q == '0) && (v_q == '0);
    end

    // Counter and sync registers; syncs idle high in reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount_o      = h_q;
    assign vcount_o      = v_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_brick_renderer.sv
// Breakout scan-out: raster timing, brick-alive bitmap with erase/reload, paddle/brick/ball colour mux.
// Latency: RGB/hsync/vsync/frame_start 1 clock after the counters; bitmap updates on the strobe edge.
// Backpressure: none; erase and reload strobes are always accepted (ignored when not applicable).
module vga_brick_renderer
    import breakout_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int BLOCK_W     = 80,
    parameter int BLOCK_H     = 30,
    parameter int SPACING_X   = 40,
    parameter int SPACING_Y   = 20,
    parameter int FIRST_ROW_Y = 40,
    parameter int BALL_SIZE   = 7,
    parameter int PADDLE_W    = 100,
    parameter int PADDLE_Y    = 441,
    parameter int PADDLE_H    = 9,
    parameter int IDX_W       = idx_width(ROWS * COLS)
) (
    input  logic             CLK_25MH,
    input  logic             reset,
    input  logic [CNT_W-1:0] paddle_pos,
    input  logic [CNT_W-1:0] ball_x,
    input  logic [CNT_W-1:0] ball_y,
    input  logic             erase_enable,
    input  logic [IDX_W-1:0] erase_pos,
    input  logic             field_reload,
    output logic [2:0]       RGB,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] hor_count,
    output logic [CNT_W-1:0] ver_count,
    output logic             frame_start,
    output logic [IDX_W:0]   bricks_left,
    output logic             field_clear
);

    localparam int             NBRICK     = ROWS * COLS;
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(NBRICK);
    localparam logic [IDX_W:0] ONE_COUNT  = (IDX_W + 1)'(1);

    coord_t hcount;
    coord_t vcount;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i         (CLK_25MH),
        .rst_i         (reset),
        .hcount_o      (hcount),
        .vcount_o      (vcount),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .frame_start_o (frame_start)
    );

    logic [NBRICK-1:0] alive_q, alive_d;
    logic [IDX_W:0]    bricks_left_q, bricks_left_d;
    logic              field_clear_q;
    rgb_t              rgb_q, rgb_d;

    // Geometry compares are done in 32-bit so that x+W never wraps at the 10-bit edge
    int px;
    int py;
    assign px = int'(hcount);
    assign py = int'(vcount);

    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_in;

    // Which brick row band / column band the current pixel falls in (bands never overlap)
    always_comb begin
        row_in = '0;
        col_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_in[r] = (py >= FIRST_ROW_Y + r * (BLOCK_H + SPACING_Y)) &&
                        (py <  FIRST_ROW_Y + r * (BLOCK_H + SPACING_Y) + BLOCK_H);
        end
        for (int c = 0; c < COLS; c++) begin
            col_in[c] = (px >= SPACING_X + c * (BLOCK_W + SPACING_X)) &&
                        (px <  SPACING_X + c * (BLOCK_W + SPACING_X) + BLOCK_W);
        end
    end

    logic active;
    logic paddle_hit;
    logic ball_hit;
    logic brick_hit;
    rgb_t brick_rgb;

    // Colour select for the current pixel: blanking, then paddle > live brick > ball
    always_comb begin
        active     = (px < H_ACTIVE) && (py < V_ACTIVE);
        paddle_hit = (px >= int'(paddle_pos)) && (px < int'(paddle_pos) + PADDLE_W) &&
                     (py >= PADDLE_Y) && (py < PADDLE_Y + PADDLE_H);
        ball_hit   = (px >= int'(ball_x)) && (px < int'(ball_x) + BALL_SIZE) &&
                     (py >= int'(ball_y)) && (py < int'(ball_y) + BALL_SIZE);
        brick_hit  = 1'b0;
        brick_rgb  = COL_BLACK;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row_in[r] && col_in[c] && alive_q[r * COLS + c]) begin
                    brick_hit = 1'b1;
                    brick_rgb = row_colour(r);
                end
            end
        end

        rgb_d = COL_BLACK;
        if (active) begin
            if (paddle_hit) begin
                rgb_d = COL_PADDLE;
            end else if (brick_hit) begin
                rgb_d = brick_rgb;
            end else if (ball_hit) begin
                rgb_d = COL_BALL;
            end
        end
    end

    // Bitmap maintenance: reload re-arms everything and swallows a same-cycle erase;
    // an erase only counts if it hits an in-range brick that is still alive
    always_comb begin
        alive_d       = alive_q;
        bricks_left_d = bricks_left_q;
        if (field_reload) begin
            alive_d       = '1;
            bricks_left_d = FULL_COUNT;
        end else if (erase_enable) begin
            for (int i = 0; i < NBRICK; i++) begin
                if ((erase_pos == IDX_W'(i)) && alive_q[i]) begin
                    alive_d[i]    = 1'b0;
                    bricks_left_d = bricks_left_q - ONE_COUNT;
                end
            end
        end
    end

    // Bitmap, live count and the cleared flag (which trails the count by one clock)
    always_ff @(posedge CLK_25MH or posedge reset) begin
        if (reset) begin
            alive_q       <= '1;
            bricks_left_q <= FULL_COUNT;
            field_clear_q <= 1'b0;
        end else begin
            alive_q       <= alive_d;
            bricks_left_q <= bricks_left_d;
            field_clear_q <= (bricks_left_q == '0);
        end
    end

    // Pixel colour register, aligned with the registered syncs
    always_ff @(posedge CLK_25MH or posedge reset) begin
        if (reset) begin
            rgb_q <= COL_BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign RGB         = rgb_q;
    assign hor_count   = hcount;
    assign ver_count   = vcount;
    assign bricks_left = bricks_left_q;
    assign field_clear = field_clear_q;

endmodule

// File: doc/vga_brick_renderer.md
# vga_brick_renderer

Parametrised successor to the Breakout VGA scan-out block: generates 640x480@60 Hz sync timing from the 25 MHz pixel clock and paints paddle, ball and a ROWS x COLS brick field with per-row colours. It owns the brick-alive bitmap, accepts erase requests from the collision logic, and reports remaining bricks and a field-cleared flag to the game FSM. All timing and geometry are parameters.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line = 800 clocks)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame = 525 lines)
- ROWS, 5, brick rows (1..8); COLS, 5, brick columns (1..8)
- BLOCK_W, 80; BLOCK_H, 30; SPACING_X, 40; SPACING_Y, 20; FIRST_ROW_Y, 40 (brick geometry, pixels)
- BALL_SIZE, 7; PADDLE_W, 100; PADDLE_Y, 441; PADDLE_H, 9
- IDX_W, derived = clog2(ROWS*COLS), brick index width
- CLK_25MH  in  1  pixel clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- paddle_pos  in  10  paddle left x
- ball_x, ball_y  in  10 each  ball top-left
- erase_enable  in  1  erase strobe, one cycle per request
- erase_pos  in  IDX_W  brick index = row*COLS + col
- field_reload  in  1  synchronous: re-arm all bricks
- RGB  out  3  pixel colour
- hsync, vsync  out  1 each  active-low syncs
- hor_count, ver_count  out  10 each  current counters
- frame_start  out  1  one-cycle pulse, aligned with the pixel at (0,0)
- bricks_left  out  IDX_W+1  live brick count
- field_clear  out  1  high while bricks_left == 0

## Operation
- Counters: hcount 0..799 wraps to 0 and increments vcount; vcount 0..524 wraps to 0. No reset-hold: counting resumes on the first edge after reset deasserts.
- hsync low iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync low iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Brick (r,c): x0 = SPACING_X + c*(BLOCK_W+SPACING_X), y0 = FIRST_ROW_Y + r*(BLOCK_H+SPACING_Y); covers [x0, x0+BLOCK_W-1] x [y0, y0+BLOCK_H-1], half-open, no shared edges.
- Row colours, row mod 5: 010, 110, 111, 100, 011. Ball 101 over [ball, ball+BALL_SIZE-1]. Paddle 001 over x [paddle_pos, paddle_pos+PADDLE_W-1], y [PADDLE_Y, PADDLE_Y+PADDLE_H-1].
- Priority: outside active area -> 000; else paddle > live brick > ball > 000.
- Erase: erase_enable with erase_pos < ROWS*COLS and bit alive -> clear bit, bricks_left -1. Out-of-range index or dead brick -> ignored, no count change.
- field_reload: all bits alive, bricks_left = ROWS*COLS. Same cycle as erase: reload wins, erase dropped.
- Reset values: hcount=0, vcount=0, RGB=000, hsync=1, vsync=1, frame_start=0, all bricks alive, bricks_left=ROWS*COLS, field_clear=0.

## Timing
- hor_count/ver_count are the counter registers. RGB, hsync, vsync, frame_start are registered from them: 1-cycle latency, all four mutually aligned.
- Erase/reload update bitmap and bricks_left on the strobe edge; the next rendered pixel uses the new bitmap. Mid-frame erase visibly clears the rest of the brick only; accepted.
- field_clear registered; asserted the cycle after bricks_left reaches 0.
- Reset asserted mid-line forces all outputs to reset values immediately; no partial state survives.

## Structure
- Shared package breakout_pkg: VGA timing constants, colour constants (COL_BALL, COL_PADDLE, row palette), brick-index width function.
- Sub-module vga_timing_gen: counters, sync generation, frame_start; the renderer instantiates it and adds bitmap, geometry compare, colour mux.
- Brick hit locator is either a per-brick compare loop or incremental row/column trackers; latency stays exactly 1.

## Test plan
- Reset, run one full frame -> hsync low for hcount 656..751, vsync low on lines 490..491, frame_start once per 420000 clocks, bricks_left=25.
- Default params, pixel (40,40) -> RGB 010 next cycle; (120,40) -> 000 (gap); (40,90) -> 110.
- erase_pos=0 then erase_pos=0 again -> pixel (40,40) becomes 000, bricks_left 25->24, second strobe ignored; erase_pos=30 -> ignored.
- Ball at (50,50) overlapping brick 0; paddle_pos=0 -> (52,52) shows 010, (0,441) shows 001, (0,440) shows 000.
- Erase all 25 -> field_clear high one cycle after last erase; field_reload with simultaneous erase -> bricks_left=25, field_clear low.
- Assert reset at hcount=300 -> all outputs at reset values immediately; counting resumes from 0 after release.
